key_event: RTL
==============

KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 SHALL have parameter LONG_CNT, default 26'd50_000_000, press length in clk cycles at which a press is a long press (1 s at 50 MHz).
REQ-002 SHALL have parameter DCLK_CNT, default 26'd12_500_000, maximum release-to-second-press gap in clk cycles for a double click (250 ms).
REQ-003 SHALL have parameter REP_CNT, default 26'd5_000_000, auto-repeat period in clk cycles (used only with KEY_EVENT_REPEAT_EN).
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port key_deb, input, 1, debounced key level from the debounce block, active-low (0 = pressed), synchronous to clk.
REQ-007 SHALL have port short_pulse, output, 1, one-cycle pulse on a single short click.
REQ-008 SHALL have port long_pulse, output, 1, one-cycle pulse when a press reaches LONG_CNT, and on each repeat when repeat is enabled.
REQ-009 SHALL have port double_pulse, output, 1, one-cycle pulse on a double click.
REQ-010 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-011 SHALL register key_deb once as key_deb_1d; press edge = ~key_deb & key_deb_1d, release edge = key_deb & ~key_deb_1d.
REQ-012 SHALL implement FSM states IDLE, PRESS1, LONG_HOLD, WAIT2, PRESS2.
REQ-013 SHALL in IDLE go to PRESS1 on a press edge and clear the timer; all other inputs are ignored.
REQ-014 SHALL in PRESS1 go to WAIT2 and clear the timer on a release edge occurring while timer < LONG_CNT-1.
REQ-015 SHALL in PRESS1 assert long_pulse and go to LONG_HOLD when timer == LONG_CNT-1 with the key still pressed; release and threshold in the same cycle resolve as long.
REQ-016 SHALL in LONG_HOLD go to IDLE on a release edge, with no further pulse.
REQ-017 SHALL in WAIT2 go to PRESS2 on a press edge while timer < DCLK_CNT-1.
REQ-018 SHALL in WAIT2 assert short_pulse and go to IDLE when timer == DCLK_CNT-1; a press edge in that same cycle is dropped.
REQ-019 SHALL in PRESS2 assert double_pulse and go to IDLE on a release edge, regardless of hold length.
REQ-020 SHALL register pulse outputs: assertion occurs in the cycle after the deciding clk edge, for exactly one cycle.
REQ-021 SHALL assert at most one of short_pulse/long_pulse/double_pulse in any cycle.
REQ-022 SHALL use a 26-bit timer that increments each cycle in PRESS1, WAIT2 and LONG_HOLD, saturates at all-ones, and clears on every state change.

Reset
REQ-023 SHALL on rst force state=IDLE, timer=0, key_deb_1d=1, and all outputs 0, asynchronously.
REQ-024 SHALL after a reset asserted mid-press emit no pulse until a new press edge is seen, even if key_deb is low at rst release.

Configuration
REQ-025 SHALL, with KEY_EVENT_REPEAT_EN defined, in LONG_HOLD re-assert long_pulse every REP_CNT cycles after the first long_pulse while the key is held, clearing the timer at each repeat.
REQ-026 SHALL, without KEY_EVENT_REPEAT_EN, emit exactly one long_pulse per long press; REP_CNT is unused.

Structure
REQ-027 SHALL place the FSM state encoding (3-bit enum) and default count constants in shared package key_event_pkg.
REQ-028 SHALL implement the timer as sub-module key_event_cnt (clear, enable, saturating 26-bit count output).

Verification
All scenarios use LONG_CNT=16, DCLK_CNT=8, REP_CNT=4.
REQ-029 SHALL verify: press 5 cycles, release, idle 20 cycles -> one short_pulse, 8 cycles after the release edge, then busy=0.
REQ-030 SHALL verify: press 3, release 3, press 3, release -> one double_pulse 1 cycle after the second release edge; no short_pulse.
REQ-031 SHALL verify: hold 40 cycles, repeat disabled -> one long_pulse 16 cycles after the press edge, nothing at release.
REQ-032 SHALL verify: hold 40 cycles, KEY_EVENT_REPEAT_EN -> long_pulse at 16 cycles, then every 4 cycles until release.
REQ-033 SHALL verify: key_deb held low and rst pulsed at cycle 10 of a press, then released -> no pulses; busy=0.
REQ-034 SHALL verify: release exactly at timer=15 in PRESS1 -> long_pulse only; second press at WAIT2 timer=7 -> short_pulse only.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared types and constants for the key_event press classifier.
package key_event_pkg;

  localparam int unsigned TMR_W = 26;

  // Default thresholds at 50 MHz: 1 s long press, 250 ms double-click gap, 100 ms repeat
  localparam logic [TMR_W-1:0] DEF_LONG_CNT = 26'd50_000_000;
  localparam logic [TMR_W-1:0] DEF_DCLK_CNT = 26'd12_500_000;
  localparam logic [TMR_W-1:0] DEF_REP_CNT  = 26'd5_000_000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HOLD = 3'd2,
    WAIT2     = 3'd3,
    PRESS2    = 3'd4
  } state_e;

  // Timer value seen in the last cycle of a cnt-cycle interval
  function automatic logic [TMR_W-1:0] term_cnt(input logic [TMR_W-1:0] cnt);
    return cnt - TMR_W'(1);
  endfunction

endpackage

// File: rtl/key_event_cnt.sv
// Saturating 26-bit interval timer with synchronous clear and count enable.
module key_event_cnt
  import key_event_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [TMR_W-1:0] cnt
);

  // Clear wins over enable; the count holds at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

endmodule

// File: rtl/key_event.sv
// Classifies a debounced active-low key into short, long and double click pulses.
// Optional feature: define KEY_EVENT_REPEAT_EN to re-fire long_pulse every REP_CNT
// cycles while a long press is held.
module key_event
  import key_event_pkg::*;
#(
  parameter logic [TMR_W-1:0] LONG_CNT = DEF_LONG_CNT,
  parameter logic [TMR_W-1:0] DCLK_CNT = DEF_DCLK_CNT,
  parameter logic [TMR_W-1:0] REP_CNT  = DEF_REP_CNT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_deb,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse,
  output logic busy
);

`ifdef KEY_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  localparam logic [TMR_W-1:0] LONG_TC = term_cnt(LONG_CNT);
  localparam logic [TMR_W-1:0] DCLK_TC = term_cnt(DCLK_CNT);
  localparam logic [TMR_W-1:0] REP_TC  = term_cnt(REP_CNT);

  state_e           state;
  logic             key_deb_1d;
  logic             smp_vld;
  logic [TMR_W-1:0] tmr;

  logic press_c;
  logic release_c;
  logic long_hit_c;
  logic dclk_hit_c;
  logic rep_hit_c;
  logic tmr_en_c;
  logic tmr_clr_c;

  // One-cycle key history; smp_vld hides the reset value of key_deb_1d so a key
  // already held at reset release is not mistaken for a fresh press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_deb_1d <= 1'b1;
      smp_vld    <= 1'b0;
    end else begin
      key_deb_1d <= key_deb;
      smp_vld    <= 1'b1;
    end
  end

  assign press_c    = smp_vld & ~key_deb & key_deb_1d;
  assign release_c  = key_deb & ~key_deb_1d;
  assign long_hit_c = (tmr == LONG_TC);
  assign dclk_hit_c = (tmr == DCLK_TC);
  assign rep_hit_c  = REP_EN & (tmr == REP_TC);
  assign tmr_en_c   = (state == PRESS1) || (state == LONG_HOLD) || (state == WAIT2);

  // Timer restarts on every state change and on each auto-repeat
  always_comb begin
    tmr_clr_c = 1'b0;
    case (state)
      IDLE:      tmr_clr_c = press_c;
      PRESS1:    tmr_clr_c = long_hit_c | release_c;
      LONG_HOLD: tmr_clr_c = key_deb | rep_hit_c;
      WAIT2:     tmr_clr_c = dclk_hit_c | press_c;
      PRESS2:    tmr_clr_c = release_c;
      default:   tmr_clr_c = 1'b1;
    endcase
  end

  key_event_cnt u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr_c),
    .en  (tmr_en_c),
    .cnt (tmr)
  );

  // Press classifier with registered one-cycle pulses and busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      double_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      double_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (press_c) begin
            state <= PRESS1;
            busy  <= 1'b1;
          end
        end
        PRESS1: begin
          // Threshold checked first so a release on the last cycle still counts as long
          if (long_hit_c) begin
            state      <= LONG_HOLD;
            long_pulse <= 1'b1;
          end else if (release_c) begin
            state <= WAIT2;
          end
        end
        LONG_HOLD: begin
          // Level test also catches a release already consumed by the long decision
          if (key_deb) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rep_hit_c) begin
            long_pulse <= 1'b1;
          end
        end
        WAIT2: begin
          // Gap expiry wins; a press on the expiry cycle is dropped
          if (dclk_hit_c) begin
            state       <= IDLE;
            short_pulse <= 1'b1;
            busy        <= 1'b0;
          end else if (press_c) begin
            state <= PRESS2;
          end
        end
        PRESS2: begin
          if (release_c) begin
            state        <= IDLE;
            double_pulse <= 1'b1;
            busy         <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
